cpu: RTL and testbench

// - Single-cycle RV32I subset core: PC, combinational instruction ROM, 32x32 register file, sign-extender and 3-bit ALU.
// - Executes R-type and I-type ALU instructions, one instruction per clock.
// - Exposes internal datapath nets as *_check outputs for bench observation.
// - Top of the cpu/ tree; ROM contents are supplied on a port, not from a file.

---
 rtl/cpu.sv | 184 ++++++++++++++++++
 tb/tb_cpu.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu.sv
// Single-cycle RV32I subset core: program counter, combinational instruction
// ROM supplied on a port, 32x32 register file, immediate sign-extender and a
// 3-bit-op ALU. Executes R-type and I-type ALU instructions, one per clock.
// Every internal datapath net of interest is exported on a *_check port.
module cpu (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] initial_instructions [0:31],
  output logic [31:0] pc_out_check,
  output logic [31:0] instruction_check,
  output logic [2:0]  alu_op_check,
  output logic [31:0] register_data_out1_check,
  output logic [31:0] register_data_out2_check,
  output logic [31:0] b_input_check,
  output logic [31:0] register_data_in_check,
  output logic [31:0] alu_result_check,
  output logic        reg_write_check,
  output logic [31:0] imm_ext_check,
  output logic        use_imm_check,
  output logic [31:0] register_check [0:31]
);

  localparam logic [6:0] OPC_R    = 7'b0110011;
  localparam logic [6:0] OPC_I    = 7'b0010011;
  localparam logic [6:0] F7_BASE  = 7'b0000000;
  localparam logic [6:0] F7_ALT   = 7'b0100000;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLL = 3'd5,
    ALU_SRL = 3'd6,
    ALU_SLT = 3'd7
  } alu_op_e;

  logic [31:0] pc_q, pc_d;
  logic [31:0] regs_q [0:31];
  logic [31:0] regs_d [0:31];

  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;

  alu_op_e     alu_op;
  logic        hit;
  logic        use_imm;
  logic        reg_write;
  logic [31:0] imm_ext;
  logic [31:0] rs1_data, rs2_data;
  logic [31:0] b_input;
  logic [31:0] alu_result;

  // Fetch: PC[1:0] are ignored and PC bits above 6 alias onto the 32-word ROM.
  assign instr  = initial_instructions[pc_q[6:2]];
  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  assign imm_ext = {{20{instr[31]}}, instr[31:20]};

  // x0 is hard-wired to zero on the read side; reads see pre-edge contents.
  assign rs1_data = (rs1 == 5'd0) ? 32'd0 : regs_q[rs1];
  assign rs2_data = (rs2 == 5'd0) ? 32'd0 : regs_q[rs2];
  assign b_input  = use_imm ? imm_ext : rs2_data;

  // Decode opcode/funct fields into ALU op, operand select and write enable.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned, which would infer a latch.
    alu_op = ALU_ADD;
    hit    = 1'b0;
    case (opcode)
      OPC_R: begin
        case (funct3)
          3'b000: begin
            if (funct7 == F7_BASE) begin
              alu_op = ALU_ADD;
              hit    = 1'b1;
            end else if (funct7 == F7_ALT) begin
              alu_op = ALU_SUB;
              hit    = 1'b1;
            end
          end
          3'b111: begin alu_op = ALU_AND; hit = 1'b1; end
          3'b110: begin alu_op = ALU_OR;  hit = 1'b1; end
          3'b100: begin alu_op = ALU_XOR; hit = 1'b1; end
          3'b001: begin alu_op = ALU_SLL; hit = 1'b1; end
          3'b101: begin
            if (funct7 == F7_BASE) begin
              alu_op = ALU_SRL;
              hit    = 1'b1;
            end
          end
          3'b010: begin alu_op = ALU_SLT; hit = 1'b1; end
          default: ;
        endcase
      end
      OPC_I: begin
        case (funct3)
          3'b000: begin alu_op = ALU_ADD; hit = 1'b1; end
          3'b111: begin alu_op = ALU_AND; hit = 1'b1; end
          3'b110: begin alu_op = ALU_OR;  hit = 1'b1; end
          3'b100: begin alu_op = ALU_XOR; hit = 1'b1; end
          3'b001: begin alu_op = ALU_SLL; hit = 1'b1; end
          3'b101: begin
            // SRAI shares funct3 with SRLI; only the logical form is supported.
            if (funct7 == F7_BASE) begin
              alu_op = ALU_SRL;
              hit    = 1'b1;
            end
          end
          3'b010: begin alu_op = ALU_SLT; hit = 1'b1; end
          default: ;
        endcase
      end
      default: ;
    endcase
    // Unrecognised encodings fall through as a NOP: ADD of rs1/rs2, no write.
    reg_write = hit;
    use_imm   = hit && (opcode == OPC_I);
  end

  // ALU: shifts use the low five bits of B, SLT compares signed.
  always_comb begin
    alu_result = 32'd0;
    case (alu_op)
      ALU_ADD: alu_result = rs1_data + b_input;
      ALU_SUB: alu_result = rs1_data - b_input;
      ALU_AND: alu_result = rs1_data & b_input;
      ALU_OR:  alu_result = rs1_data | b_input;
      ALU_XOR: alu_result = rs1_data ^ b_input;
      ALU_SLL: alu_result = rs1_data << b_input[4:0];
      ALU_SRL: alu_result = rs1_data >> b_input[4:0];
      ALU_SLT: alu_result = {31'd0, $signed(rs1_data) < $signed(b_input)};
      default: alu_result = rs1_data + b_input;
    endcase
  end

  // Next-state: PC advances every cycle; the write port drops writes to x0.
  always_comb begin
    pc_d   = pc_q + 32'd4;
    regs_d = regs_q;
    if (reg_write && (rd != 5'd0)) begin
      regs_d[rd] = alu_result;
    end
  end

  // State update with synchronous reset taking priority over PC and writes.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (reset) begin
      pc_q      <= 32'd0;
      // NOTE: the register file is deliberately reset to known values (x0=0, xi=3000+i), unlike a typical RAM-backed file.
      regs_q[0] <= 32'd0;
      for (int i = 1; i < 32; i++) begin
        regs_q[i] <= 32'd3000 + 32'(i);
      end
    end else begin
      pc_q   <= pc_d;
      regs_q <= regs_d;
    end
  end

  assign pc_out_check             = pc_q;
  assign instruction_check        = instr;
  assign alu_op_check             = alu_op;
  assign register_data_out1_check = rs1_data;
  assign register_data_out2_check = rs2_data;
  assign b_input_check            = b_input;
  assign register_data_in_check   = alu_result;
  assign alu_result_check         = alu_result;
  assign reg_write_check          = reg_write;
  assign imm_ext_check            = imm_ext;
  assign use_imm_check            = use_imm;
  assign register_check           = regs_q;

endmodule

// File: tb/tb_cpu.sv
// Self-checking bench for cpu: directed programs from the datasheet examples,
// an ALU-op sweep, then random programs with a mid-run reset, all compared
// against an instruction-level reference model.
module tb_cpu;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] rom [0:31];

  logic [31:0] pc_out, instr_out, out1, out2, b_in, data_in, alu_res, imm_out;
  logic [2:0]  alu_op_out;
  logic        reg_write_out, use_imm_out;
  logic [31:0] reg_chk [0:31];

  int checks = 0;
  int errors = 0;

  // Architectural model: register values and program counter.
  int unsigned mregs [0:31];
  int unsigned mpc = 0;

  typedef enum {K_ADD, K_SUB, K_AND, K_OR, K_XOR, K_SLL, K_SRL, K_SLT, K_NOP} kind_e;

  typedef struct {
    kind_e       kind;
    logic [2:0]  op;
    logic        uimm;
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] rs2v;
    logic [31:0] imm;
    logic [31:0] res;
  } pred_t;

  cpu dut (
    .clk                      (clk),
    .reset                    (reset),
    .initial_instructions     (rom),
    .pc_out_check             (pc_out),
    .instruction_check        (instr_out),
    .alu_op_check             (alu_op_out),
    .register_data_out1_check (out1),
    .register_data_out2_check (out2),
    .b_input_check            (b_in),
    .register_data_in_check   (data_in),
    .alu_result_check         (alu_res),
    .reg_write_check          (reg_write_out),
    .imm_ext_check            (imm_out),
    .use_imm_check            (use_imm_out),
    .register_check           (reg_chk)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'h13};
  endfunction

  // Instruction-set view: name the instruction from its fields.
  function automatic kind_e classify(input logic [31:0] ins);
    int opc;
    int f3;
    int f7;
    opc = int'(ins[6:0]);
    f3  = int'(ins[14:12]);
    f7  = int'(ins[31:25]);
    if (opc == 'h33) begin
      if (f3 == 0 && f7 == 0)     return K_ADD;
      if (f3 == 0 && f7 == 'h20)  return K_SUB;
      if (f3 == 7)                return K_AND;
      if (f3 == 6)                return K_OR;
      if (f3 == 4)                return K_XOR;
      if (f3 == 1)                return K_SLL;
      if (f3 == 5 && f7 == 0)     return K_SRL;
      if (f3 == 2)                return K_SLT;
    end else if (opc == 'h13) begin
      if (f3 == 0)                return K_ADD;
      if (f3 == 7)                return K_AND;
      if (f3 == 6)                return K_OR;
      if (f3 == 4)                return K_XOR;
      if (f3 == 1)                return K_SLL;
      if (f3 == 5 && f7 == 0)     return K_SRL;
      if (f3 == 2)                return K_SLT;
    end
    return K_NOP;
  endfunction

  function automatic logic [2:0] op_code(input kind_e k);
    case (k)
      K_SUB:   return 3'd1;
      K_AND:   return 3'd2;
      K_OR:    return 3'd3;
      K_XOR:   return 3'd4;
      K_SLL:   return 3'd5;
      K_SRL:   return 3'd6;
      K_SLT:   return 3'd7;
      default: return 3'd0;
    endcase
  endfunction

  function automatic pred_t predict(input logic [31:0] ins);
    pred_t p;
    int    sh;
    int    imm_i;
    p.kind = classify(ins);
    p.op   = op_code(p.kind);
    p.rw   = (p.kind != K_NOP);
    p.uimm = p.rw && (ins[6:0] == 7'h13);
    p.rd   = ins[11:7];
    imm_i  = int'(ins[31:20]);
    if (imm_i >= 2048) imm_i = imm_i - 4096;
    p.imm  = 32'(imm_i);
    p.a    = (ins[19:15] == 5'd0) ? 32'd0 : 32'(mregs[ins[19:15]]);
    p.rs2v = (ins[24:20] == 5'd0) ? 32'd0 : 32'(mregs[ins[24:20]]);
    p.b    = p.uimm ? p.imm : p.rs2v;
    sh     = int'(p.b % 32);
    case (p.kind)
      K_SUB:   p.res = p.a - p.b;
      K_AND:   p.res = p.a & p.b;
      K_OR:    p.res = p.a | p.b;
      K_XOR:   p.res = p.a ^ p.b;
      K_SLL:   p.res = p.a * (32'd1 << sh);
      K_SRL:   p.res = p.a / (32'd1 << sh);
      K_SLT:   p.res = (int'(p.a) < int'(p.b)) ? 32'd1 : 32'd0;
      default: p.res = p.a + p.b;
    endcase
    return p;
  endfunction

  function automatic logic [31:0] gen_instr();
    int          kind;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [11:0] imm;
    kind = int'($urandom_range(0, 9));
    f3   = 3'($urandom_range(0, 7));
    if (kind <= 3) begin
      f7 = ((f3 == 3'd0 || f3 == 3'd5) && ($urandom_range(0, 1) == 1)) ? 7'h20 : 7'h00;
      return enc_r(f7, 5'($urandom), 5'($urandom), f3, 5'($urandom));
    end else if (kind <= 7) begin
      imm = 12'($urandom);
      if ((f3 == 3'd1 || f3 == 3'd5) && ($urandom_range(0, 3) != 0)) imm[11:5] = 7'd0;
      return enc_i(imm, 5'($urandom), f3, 5'($urandom));
    end else if (kind == 8) begin
      return 32'($urandom);
    end
    return 32'd0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Compare every combinational view against the model for the current PC.
  task automatic check_cycle(input string ctx);
    pred_t p;
    p = predict(rom[mpc[6:2]]);
    check({ctx, ".pc"},        pc_out,                mpc);
    check({ctx, ".instr"},     instr_out,             rom[mpc[6:2]]);
    check({ctx, ".alu_op"},    {29'd0, alu_op_out},   {29'd0, p.op});
    check({ctx, ".out1"},      out1,                  p.a);
    check({ctx, ".out2"},      out2,                  p.rs2v);
    check({ctx, ".b_input"},   b_in,                  p.b);
    check({ctx, ".alu_res"},   alu_res,               p.res);
    check({ctx, ".data_in"},   data_in,               p.res);
    check({ctx, ".reg_write"}, {31'd0, reg_write_out}, {31'd0, p.rw});
    check({ctx, ".use_imm"},   {31'd0, use_imm_out},  {31'd0, p.uimm});
    check({ctx, ".imm_ext"},   imm_out,               p.imm);
  endtask

  task automatic check_regs(input string ctx);
    for (int i = 0; i < 32; i++) begin
      check($sformatf("%s.x%0d", ctx, i), reg_chk[i], 32'(mregs[i]));
    end
  endtask

  // One clock edge, optionally with reset asserted; the model follows.
  task automatic tick(input bit rst);
    pred_t p;
    p = predict(rom[mpc[6:2]]);
    reset = rst;
    @(posedge clk);
    #1;
    reset = 1'b0;
    if (rst) begin
      mpc = 0;
      mregs[0] = 0;
      for (int i = 1; i < 32; i++) mregs[i] = 3000 + i;
    end else begin
      if (p.rw && p.rd != 5'd0) mregs[p.rd] = p.res;
      mpc = mpc + 4;
    end
  endtask

  initial begin
    // Phase 1: datasheet example program, then ROM wrap-around.
    for (int i = 0; i < 32; i++) rom[i] = 32'd0;
    rom[0] = 32'h005303b3;
    rom[1] = 32'h40848533;
    rom[2] = enc_i(12'd1, 5'd12, 3'd0, 5'd13);
    tick(1'b1);
    check("rst.pc",        pc_out,                 32'd0);
    check("rst.alu_op",    {29'd0, alu_op_out},    32'd0);
    check("rst.out1",      out1,                   32'd3006);
    check("rst.out2",      out2,                   32'd3005);
    check("rst.alu_res",   alu_res,                32'd6011);
    check("rst.use_imm",   {31'd0, use_imm_out},   32'd0);
    check("rst.reg_write", {31'd0, reg_write_out}, 32'd1);
    check("rst.x7",        reg_chk[7],             32'd3007);
    check_cycle("p1.c0");
    tick(1'b0);
    check("add.x7",        reg_chk[7],             32'd6011);
    check("sub.pc",        pc_out,                 32'd4);
    check("sub.alu_op",    {29'd0, alu_op_out},    32'd1);
    check("sub.out1",      out1,                   32'd3009);
    check("sub.out2",      out2,                   32'd3008);
    check("sub.alu_res",   alu_res,                32'd1);
    check_cycle("p1.c1");
    tick(1'b0);
    check("addi.pc",       pc_out,                 32'd8);
    check("addi.use_imm",  {31'd0, use_imm_out},   32'd1);
    check("addi.imm_ext",  imm_out,                32'd1);
    check("addi.b_input",  b_in,                   32'd1);
    check("addi.out1",     out1,                   32'd3012);
    check("addi.alu_res",  alu_res,                32'd3013);
    check_cycle("p1.c2");
    tick(1'b0);
    check("addi.x13",      reg_chk[13],            32'd3013);
    check("nop.reg_write", {31'd0, reg_write_out}, 32'd0);
    for (int c = 3; c < 32; c++) begin
      check_cycle($sformatf("p1.c%0d", c));
      tick(1'b0);
    end
    check("wrap.pc",       pc_out,                 32'd128);
    check("wrap.instr",    instr_out,              32'h005303b3);
    check("wrap.x10",      reg_chk[10],            32'd1);
    check_regs("wrap");

    // Phase 2: every ALU op on a=4, b=2, signed SLT, all-ones immediate, x0 write.
    for (int i = 0; i < 32; i++) rom[i] = 32'd0;
    rom[0]  = enc_i(12'd4, 5'd0, 3'd0, 5'd1);
    rom[1]  = enc_i(12'd2, 5'd0, 3'd0, 5'd2);
    rom[2]  = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3);
    rom[3]  = enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd4);
    rom[4]  = enc_r(7'h00, 5'd2, 5'd1, 3'd7, 5'd5);
    rom[5]  = enc_r(7'h00, 5'd2, 5'd1, 3'd6, 5'd6);
    rom[6]  = enc_r(7'h00, 5'd2, 5'd1, 3'd4, 5'd7);
    rom[7]  = enc_r(7'h00, 5'd2, 5'd1, 3'd1, 5'd8);
    rom[8]  = enc_r(7'h00, 5'd2, 5'd1, 3'd5, 5'd9);
    rom[9]  = enc_r(7'h00, 5'd2, 5'd1, 3'd2, 5'd10);
    rom[10] = enc_i(12'hFFF, 5'd0, 3'd0, 5'd11);
    rom[11] = enc_r(7'h00, 5'd0, 5'd11, 3'd2, 5'd12);
    rom[12] = enc_i(12'd5, 5'd1, 3'd0, 5'd0);
    tick(1'b1);
    for (int c = 0; c < 13; c++) begin
      check_cycle($sformatf("p2.c%0d", c));
      if (c == 10) check("imm_fff.imm_ext", imm_out, 32'hFFFFFFFF);
      tick(1'b0);
    end
    check("alu.add", reg_chk[3],  32'd6);
    check("alu.sub", reg_chk[4],  32'd2);
    check("alu.and", reg_chk[5],  32'd0);
    check("alu.or",  reg_chk[6],  32'd6);
    check("alu.xor", reg_chk[7],  32'd6);
    check("alu.sll", reg_chk[8],  32'd16);
    check("alu.srl", reg_chk[9],  32'd1);
    check("alu.slt", reg_chk[10], 32'd0);
    check("alu.neg1", reg_chk[11], 32'hFFFFFFFF);
    check("alu.slt_neg", reg_chk[12], 32'd1);
    check("x0.stays0", reg_chk[0], 32'd0);
    check_regs("p2");

    // Phase 3: random programs with a reset asserted mid-run.
    for (int i = 0; i < 32; i++) rom[i] = gen_instr();
    tick(1'b1);
    for (int c = 0; c < 120; c++) begin
      check_cycle($sformatf("p3.c%0d", c));
      if (c == 60) begin
        tick(1'b1);
        check("midrst.pc", pc_out, 32'd0);
        check("midrst.x5", reg_chk[5], 32'd3005);
        check_regs("midrst");
      end else begin
        tick(1'b0);
        if (c % 8 == 7) check_regs($sformatf("p3.c%0d", c));
      end
    end
    check_regs("p3.end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
